// File: rtl/pipelined_wallace_multiplier.sv
// Pipelined Wallace-tree multiplier with Baugh-Wooley signed support.
// Reduction levels are spread across STAGES registers; the last stage holds the final adder.
module pipelined_wallace_multiplier #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 overflow
);

   localparam int PW    = 2 * WIDTH;
   localparam int NROWS = WIDTH + 1;

   // Row count after a number of 3:2 compression levels.
   function automatic int rows_at(input int lvl);
      int r;
      r = NROWS;
      for (int i = 0; i < lvl; i++) r = 2 * (r / 3) + r % 3;
      return r;
   endfunction

   function automatic int count_levels(input int rows);
      int r;
      int n;
      r = rows;
      n = 0;
      while (r > 2) begin
         r = 2 * (r / 3) + r % 3;
         n++;
      end
      return n;
   endfunction

   localparam int LEVELS = count_levels(NROWS);

   // A level is registered when it closes one of the first STAGES-1 stages.
   function automatic bit is_boundary(input int lvl);
      bit hit;
      hit = 1'b0;
      for (int s = 0; s < STAGES - 1; s++)
         if (((s + 1) * LEVELS) / STAGES == lvl) hit = 1'b1;
      return hit;
   endfunction

   logic stall;
   logic advance;

   assign stall    = out_valid & ~out_ready;
   assign advance  = ~stall;
   assign in_ready = ~reset & ~stall;

   for (genvar l = 0; l <= LEVELS; l++) begin : lv
      localparam int R = rows_at(l);
      logic [PW-1:0] pre_r [R];
      logic [PW-1:0] v_r   [R];
      logic          pre_vld;
      logic          pre_md;
      logic          vld;
      logic          md;

      if (l == 0) begin : gen_pp
         // Baugh-Wooley: complement the bits that pair exactly one sign bit,
         // then add constant ones at bit WIDTH and bit 2*WIDTH-1.
         for (genvar i = 0; i < WIDTH; i++) begin : gen_row
            logic [WIDTH-1:0] inv_mask;
            if (i == WIDTH - 1) begin : gen_last
               assign inv_mask = {1'b0, {(WIDTH-1){signed_mode}}};
            end else begin : gen_mid
               assign inv_mask = {signed_mode, {(WIDTH-1){1'b0}}};
            end
            assign pre_r[i] = PW'(({WIDTH{multiplier[i]}} & multiplicand) ^ inv_mask) << i;
         end
         assign pre_r[WIDTH] = {signed_mode, {(PW-WIDTH-2){1'b0}}, signed_mode, {WIDTH{1'b0}}};
         assign pre_vld = in_valid & in_ready;
         assign pre_md  = signed_mode;
      end else begin : gen_csa
         localparam int RP = rows_at(l - 1);
         localparam int G  = RP / 3;
         for (genvar g = 0; g < G; g++) begin : gen_grp
            logic [PW-1:0] x;
            logic [PW-1:0] y;
            logic [PW-1:0] z;
            assign x = lv[l-1].v_r[3*g];
            assign y = lv[l-1].v_r[3*g+1];
            assign z = lv[l-1].v_r[3*g+2];
            assign pre_r[2*g]   = x ^ y ^ z;
            assign pre_r[2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
         end
         for (genvar k = 0; k < RP - 3 * G; k++) begin : gen_pass
            assign pre_r[2*G+k] = lv[l-1].v_r[3*G+k];
         end
         assign pre_vld = lv[l-1].vld;
         assign pre_md  = lv[l-1].md;
      end

      if (is_boundary(l)) begin : gen_reg
         always_ff @(posedge clk) begin
            if (reset) begin
               vld <= 1'b0;
            end else if (advance) begin
               vld <= pre_vld;
               md  <= pre_md;
               v_r <= pre_r;
            end
         end
      end else begin : gen_wire
         assign vld = pre_vld;
         assign md  = pre_md;
         assign v_r = pre_r;
      end
   end

   logic [PW-1:0] sum;
   logic          sum_ovf;

   always_comb begin
      sum = lv[LEVELS].v_r[0] + lv[LEVELS].v_r[1];
      if (lv[LEVELS].md)
         sum_ovf = ~((&sum[PW-1:WIDTH-1]) | ~(|sum[PW-1:WIDTH-1]));
      else
         sum_ovf = |sum[PW-1:WIDTH];
   end

   // Output register only loads on real results so bubbles leave product untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         product   <= '0;
         overflow  <= 1'b0;
      end else if (advance) begin
         out_valid <= lv[LEVELS].vld;
         if (lv[LEVELS].vld) begin
            product  <= sum;
            overflow <= sum_ovf;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// Directed bench for pipelined_wallace_multiplier (WIDTH=32, STAGES=3).
module tb_pipelined_wallace_multiplier;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        signed_mode;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   pipelined_wallace_multiplier #(.WIDTH(32), .STAGES(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .signed_mode  (signed_mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        m;
      logic [63:0] p;
      logic        o;
   } vec_t;

   vec_t vecs [10];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic m);
      in_valid     = 1'b1;
      multiplicand = a;
      multiplier   = b;
      signed_mode  = m;
      @(negedge clk);
   endtask

   task automatic waitResult(input string tag, input logic [63:0] exp_p, input logic exp_o, output int waited);
      waited = 0;
      while (out_valid !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, "_product"}, product, exp_p);
      checkOutput({tag, "_overflow"}, 64'(overflow), 64'(exp_o));
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w;
      int w2;

      vecs[0] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001, 1'b1};
      vecs[1] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1};
      vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1};
      vecs[3] = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 64'h0000_0000_8000_0000, 1'b1};
      vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0};
      vecs[5] = '{32'h0000_FFFF, 32'h0001_0001, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0};
      vecs[6] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b1};
      vecs[7] = '{32'h0000_0000, 32'd456,       1'b1, 64'h0,                   1'b0};
      vecs[8] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 64'h0,                   1'b0};
      vecs[9] = '{32'h8000_0000, 32'h0000_0000, 1'b1, 64'h0,                   1'b0};

      reset        = 1'b1;
      in_valid     = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      signed_mode  = 1'b0;
      out_ready    = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_product", product, 64'd0);
      checkOutput("rst_overflow", 64'(overflow), 64'd0);

      reset = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

      applyStimulus(32'd123, 32'd456, 1'b1);
      in_valid = 1'b0;
      waitResult("signed_123x456", 64'd56088, 1'b0, w);
      checkOutput("latency", 64'(w + 1), 64'd3);
      checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
      checkOutput("idle_product_held", product, 64'd56088);

      applyStimulus(32'hFFFF_FF85, 32'd456, 1'b1);
      applyStimulus(32'hFFFF_FF85, 32'hFFFF_FE38, 1'b1);
      in_valid = 1'b0;
      waitResult("neg123x456", 64'hFFFF_FFFF_FFFF_24E8, 1'b0, w);
      waitResult("neg123xneg456", 64'd56088, 1'b0, w2);
      checkOutput("back_to_back_gap", 64'(w2), 64'd0);

      fork
         begin
            for (int i = 0; i < 10; i++)
               applyStimulus(vecs[i].a, vecs[i].b, vecs[i].m);
            in_valid = 1'b0;
         end
         begin
            int wv;
            for (int j = 0; j < 10; j++)
               waitResult($sformatf("vec%0d", j), vecs[j].p, vecs[j].o, wv);
         end
      join

      // Stall at the first of four back-to-back results.
      applyStimulus(32'd3, 32'd5, 1'b0);
      applyStimulus(32'd100, 32'd200, 1'b0);
      applyStimulus(32'hFFFF_FFF9, 32'd9, 1'b1);
      in_valid     = 1'b1;
      multiplicand = 32'h0001_0000;
      multiplier   = 32'h0001_0000;
      signed_mode  = 1'b0;
      out_ready    = 1'b0;
      #1;
      checkOutput("stall0_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall0_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall0_product", product, 64'd15);
      @(negedge clk);
      checkOutput("stall1_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall1_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall1_product", product, 64'd15);
      @(negedge clk);
      checkOutput("stall2_product", product, 64'd15);
      checkOutput("stall2_overflow", 64'(overflow), 64'd0);
      out_ready = 1'b1;
      #1;
      checkOutput("unstall_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      waitResult("stall_b", 64'd20000, 1'b0, w);
      checkOutput("stall_b_gap", 64'(w), 64'd0);
      waitResult("stall_c", 64'hFFFF_FFFF_FFFF_FFC1, 1'b0, w);
      waitResult("stall_d", 64'h0000_0001_0000_0000, 1'b1, w);

      // Reset with two operations in flight.
      applyStimulus(32'd11, 32'd13, 1'b0);
      applyStimulus(32'd17, 32'd19, 1'b0);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("flush%0d_out_valid", k), 64'(out_valid), 64'd0);
         @(negedge clk);
      end
      applyStimulus(32'd7, 32'd6, 1'b0);
      in_valid = 1'b0;
      waitResult("after_flush_7x6", 64'd42, 1'b0, w);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_wallace_multiplier.md
PIPELINED_WALLACE_MULTIPLIER -- requirements
Module: pipelined_wallace_multiplier

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width (legal range 4..64).
REQ-002 Parameter STAGES, default 3, SHALL set the pipeline depth in cycles (legal range 1..4).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  SHALL indicate that multiplicand, multiplier and signed_mode are valid.
REQ-006 in_ready  output  1  SHALL indicate the block accepts an operation this cycle.
REQ-007 multiplicand  input  WIDTH  SHALL be operand A.
REQ-008 multiplier  input  WIDTH  SHALL be operand B.
REQ-009 signed_mode  input  1  SHALL select the operand format: 1 = two's complement, 0 = unsigned; it is captured per operation.
REQ-010 out_valid  output  1  SHALL indicate that product and overflow are valid.
REQ-011 out_ready  input  1  SHALL indicate that the consumer accepts the result this cycle.
REQ-012 product  output  2*WIDTH  SHALL be the full-width product, in the format selected by the captured signed_mode.
REQ-013 overflow  output  1  SHALL flag a product that does not fit in WIDTH bits.

Function
REQ-014 Acceptance SHALL occur only when in_valid and in_ready are both 1 in the same cycle.
REQ-015 A result transfer SHALL occur only when out_valid and out_ready are both 1 in the same cycle.
REQ-016 Partial products SHALL be generated and then reduced by a Wallace tree of 3:2 carry-save adders, followed by a final carry-propagate adder.
REQ-017 Signed mode SHALL use Baugh-Wooley sign correction; no operand negation pre-pass SHALL be used.
REQ-018 Pipeline registers SHALL split the reduction levels evenly across STAGES, and the final carry-propagate adder SHALL sit in the last stage.
REQ-019 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when no stall occurs.
REQ-020 Throughput SHALL be one operation per cycle when out_ready is held at 1.
REQ-021 Each stage SHALL carry a valid bit; a stage with its valid bit at 0 SHALL be a bubble.
REQ-022 Stall: when out_valid=1 and out_ready=0, every stage SHALL hold its contents and in_ready SHALL be 0.
REQ-023 Otherwise in_ready SHALL be 1, and bubbles SHALL advance without loss.
REQ-024 product and overflow SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Results SHALL emerge in acceptance order; no operation SHALL be dropped or duplicated.
REQ-026 Overflow in signed mode SHALL be 1 iff the product lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-027 Overflow in unsigned mode SHALL be 1 iff the product is 2^WIDTH or greater.
REQ-028 Signed most-negative times most-negative SHALL produce +2^(2*WIDTH-2) exactly, with no wrap, and overflow=1.
REQ-029 A zero operand SHALL produce product 0 and overflow 0, irrespective of mode.
REQ-030 When out_valid=0, product and overflow SHALL hold their last value; consumers SHALL ignore them.

Reset
REQ-031 While reset=1: all stage valid bits SHALL be cleared, out_valid=0, product=0, overflow=0, in_ready=0.
REQ-032 In the first cycle after reset deasserts, in_ready SHALL be 1.
REQ-033 Reset mid-operation SHALL discard all in-flight operations; no pre-reset result SHALL ever be presented.
REQ-034 Reset SHALL take priority over a simultaneous acceptance or transfer.

Verification (WIDTH=32, STAGES=3)
REQ-035 Reset, then signed 123*456, 1 cycle -> out_valid exactly 3 cycles later, product=56088, overflow=0.
REQ-036 Signed -123*456, then -123*-456, back-to-back -> -56088 then 56088, on consecutive cycles, overflow=0 for both.
REQ-037 Signed 0x7FFFFFFF*0x7FFFFFFF -> 0x3FFFFFFF00000001, overflow=1.
REQ-037 (cont.) Signed 0x80000000*0x80000000 -> 0x4000000000000000, overflow=1.
REQ-037 (cont.) Unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE00000001, overflow=1.
REQ-038 Four ops back-to-back, out_ready=0 for 2 cycles at the first result -> in_ready=0 during the stall, product held, all 4 results delivered in order.
REQ-039 Reset asserted for 1 cycle with 2 ops in flight -> out_valid=0 from the next cycle, no stale result, and a new 7*6 afterwards returns 42.
REQ-040 Signed 0*456 and unsigned 0*0xFFFFFFFF -> product=0, overflow=0.
